frame_stream_source: RTL and testbench

Avalon-ST video source that reads a stored frame from a synchronous-read frame buffer RAM and emits it as a 12-bit RGB444 pixel stream with sop/eop/valid framing, honouring ready backpressure. It sits upstream of the filter selection stage as the transmitting end of the same stream interface. It replaces ad-hoc bench drivers and camera-less test paths with a deterministic, backpressure-correct frame player.

---
 rtl/video_stream_pkg.sv | 14 +
 rtl/frame_stream_source_if.sv | 26 ++
 rtl/stream_skid_buffer.sv | 71 +++++++
 rtl/frame_stream_source.sv | 120 ++++++++++++
 tb/tb_frame_stream_source.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/video_stream_pkg.sv
// Shared constants and state type for the video stream source blocks.
package video_stream_pkg;

    localparam int DATA_W     = 12;
    localparam int DEF_WIDTH  = 320;
    localparam int DEF_HEIGHT = 240;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } src_state_t;

endpackage

// File: rtl/frame_stream_source_if.sv
// Frame buffer read port plus Avalon-ST pixel stream, seen from the source (master) or sink (slave).
interface frame_stream_source_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = video_stream_pkg::DATA_W
);

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              ready_in;
    logic [DATA_W-1:0] data_out;
    logic              sop_out;
    logic              eop_out;
    logic              valid_out;

    modport master (
        output rd_en, rd_addr, data_out, sop_out, eop_out, valid_out,
        input  rd_data, ready_in
    );

    modport slave (
        input  rd_en, rd_addr, data_out, sop_out, eop_out, valid_out,
        output rd_data, ready_in
    );

endinterface

// File: rtl/stream_skid_buffer.sv
// Two-entry FIFO of {eop, sop, data} feeding a registered output stage that holds steady under backpressure.
module stream_skid_buffer #(
    parameter int DATA_W = video_stream_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W+1:0] push_word_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              sop_o,
    output logic              eop_o,
    output logic              valid_o,
    output logic              pop_o,
    output logic [1:0]        count_o
);

    localparam int WORD_W = DATA_W + 2;

    logic [WORD_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic [1:0]        count_d;
    logic [WORD_W-1:0] head_q;
    logic              valid_q;
    logic              pop;

    // The output stage refills whenever it is empty or its current beat is being taken.
    assign pop     = (count_q != 2'd0) && (!valid_q || ready_i);
    assign count_d = count_q + {1'b0, push_i} - {1'b0, pop};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_word_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            valid_q <= 1'b0;
        end else if (pop) begin
            head_q  <= mem_q[rd_ptr_q];
            valid_q <= 1'b1;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = head_q[DATA_W-1:0];
    assign sop_o   = head_q[DATA_W];
    assign eop_o   = head_q[DATA_W+1];
    assign valid_o = valid_q;
    assign pop_o   = pop;
    assign count_o = count_q;

endmodule

// File: rtl/frame_stream_source.sv
// Plays a stored frame out of a frame buffer RAM as a sop/eop-framed pixel stream with backpressure.
module frame_stream_source #(
    parameter int WIDTH  = video_stream_pkg::DEF_WIDTH,
    parameter int HEIGHT = video_stream_pkg::DEF_HEIGHT,
    parameter int ADDR_W = 17,
    parameter int DATA_W = video_stream_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    frame_stream_source_if.master bus,
    output logic                  frame_done,
    output logic                  busy
);

    import video_stream_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    src_state_t        state_q;
    src_state_t        state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] rd_addr_d;
    logic              rd_en_q;
    logic              frame_done_q;
    logic              issue;
    logic              room;
    logic [2:0]        committed;
    logic              pop;
    logic [1:0]        count;
    logic [DATA_W-1:0] data_o;
    logic              sop_o;
    logic              eop_o;
    logic              valid_o;
    logic              eop_xfer;

    // Reads in flight are counted against the buffer so a returning word always has a slot.
    assign committed = {1'b0, count} + {2'b0, rd_en_q} - {2'b0, pop};
    assign room      = committed < 3'd2;
    assign eop_xfer  = valid_o && bus.ready_in && eop_o;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_addr_d = rd_addr_q;
        issue     = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = STREAM;
                    cnt_d   = '0;
                end
            end
            STREAM: begin
                if (room) begin
                    issue     = 1'b1;
                    rd_addr_d = cnt_q;
                    if (cnt_q == LAST_ADDR) begin
                        cnt_d = '0;
                        if (!enable) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (eop_xfer && count == 2'd0 && !rd_en_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_en_q      <= issue;
            rd_addr_q    <= rd_addr_d;
            frame_done_q <= eop_xfer;
        end
    end

    stream_skid_buffer #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .push_i      (rd_en_q),
        .push_word_i ({rd_addr_q == LAST_ADDR, rd_addr_q == '0, bus.rd_data}),
        .ready_i     (bus.ready_in),
        .data_o      (data_o),
        .sop_o       (sop_o),
        .eop_o       (eop_o),
        .valid_o     (valid_o),
        .pop_o       (pop),
        .count_o     (count)
    );

    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.data_out  = data_o;
    assign bus.sop_out   = sop_o;
    assign bus.eop_out   = eop_o;
    assign bus.valid_out = valid_o;
    assign frame_done    = frame_done_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_frame_stream_source.sv
// Directed bench for frame_stream_source on a 4x2 frame: scoreboard of expected beats plus per-cycle protocol checks.
module tb_frame_stream_source;

    localparam int WIDTH  = 4;
    localparam int HEIGHT = 2;
    localparam int N      = WIDTH * HEIGHT;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 12;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } beat_t;

    logic              clk;
    logic              reset;
    logic              enable;
    logic              frameDone;
    logic              busy;
    logic [DATA_W-1:0] mem [N];

    int compared   = 0;
    int mismatched = 0;

    beat_t expQ[$];
    int    beatCount   = 0;
    int    doneCount   = 0;
    int    issuedCount = 0;
    int    xferCount   = 0;
    int    run         = 0;
    int    lastRun     = 0;
    logic  pendingDone = 1'b0;
    logic  prevValid   = 1'b0;
    logic  prevReady   = 1'b0;
    logic  prevSop     = 1'b0;
    logic  prevEop     = 1'b0;
    logic [DATA_W-1:0] prevData = '0;

    frame_stream_source_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    frame_stream_source #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .bus        (bus),
        .frame_done (frameDone),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM whose data belongs to the read registered on the previous edge; garbage otherwise.
    assign bus.rd_data = bus.rd_en ? mem[bus.rd_addr] : 12'hBAD;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic rdy);
        enable       = en;
        bus.ready_in = rdy;
    endtask

    task automatic pushFrame();
        beat_t b;
        for (int i = 0; i < N; i++) begin
            b.data = DATA_W'(12'h100 + i);
            b.sop  = (i == 0);
            b.eop  = (i == N - 1);
            expQ.push_back(b);
        end
    endtask

    task automatic waitIdle(input string tag, input int maxCycles);
        int n;
        n = 0;
        while ((expQ.size() != 0 || busy) && n < maxCycles) begin
            tick();
            n++;
        end
        checkOutput({tag, "_timeout"}, n < maxCycles, 1'b1);
        tick();
        tick();
    endtask

    // Monitor: scoreboard pops, stall stability, frame_done timing and outstanding-read bound.
    always @(negedge clk) begin
        beat_t e;
        if (reset !== 1'b0) begin
            pendingDone = 1'b0;
            prevValid   = 1'b0;
            issuedCount = 0;
            xferCount   = 0;
            run         = 0;
        end else begin
            checkOutput("frame_done", frameDone, pendingDone);
            if (frameDone) doneCount++;
            if (prevValid && !prevReady) begin
                checkOutput("stall_valid", bus.valid_out, 1'b1);
                checkOutput("stall_data", bus.data_out, prevData);
                checkOutput("stall_sop", bus.sop_out, prevSop);
                checkOutput("stall_eop", bus.eop_out, prevEop);
            end
            if (bus.rd_en) issuedCount++;
            if (bus.valid_out && bus.ready_in) begin
                xferCount++;
                beatCount++;
                checkOutput("beat_expected", expQ.size() != 0, 1'b1);
                if (expQ.size() != 0) begin
                    e = expQ.pop_front();
                    checkOutput("beat_data", bus.data_out, e.data);
                    checkOutput("beat_sop", bus.sop_out, e.sop);
                    checkOutput("beat_eop", bus.eop_out, e.eop);
                end
            end
            checkOutput("outstanding_le3", (issuedCount - xferCount) <= 3, 1'b1);
            if (bus.valid_out) begin
                run++;
            end else if (run > 0) begin
                lastRun = run;
                run     = 0;
            end
            pendingDone = bus.valid_out && bus.ready_in && bus.eop_out;
            prevValid   = bus.valid_out;
            prevReady   = bus.ready_in;
            prevData    = bus.data_out;
            prevSop     = bus.sop_out;
            prevEop     = bus.eop_out;
        end
    end

    initial begin
        int doneBase;
        int beatBase;
        int n;
        logic rdy;

        for (int i = 0; i < N; i++) mem[i] = DATA_W'(12'h100 + i);

        // Reset held with enable requested: everything quiet.
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1);
        repeat (3) tick();
        checkOutput("rst_rd_en", bus.rd_en, 1'b0);
        checkOutput("rst_rd_addr", bus.rd_addr, 0);
        checkOutput("rst_valid", bus.valid_out, 1'b0);
        checkOutput("rst_sop", bus.sop_out, 1'b0);
        checkOutput("rst_eop", bus.eop_out, 1'b0);
        checkOutput("rst_data", bus.data_out, 0);
        checkOutput("rst_frame_done", frameDone, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);

        // Single frame with one-cycle enable, checking the 3-edge latency.
        pushFrame();
        doneBase = doneCount;
        @(negedge clk);
        reset = 1'b0;
        tick();
        applyStimulus(1'b0, 1'b1);
        checkOutput("lat_e0_busy", busy, 1'b1);
        checkOutput("lat_e0_rd_en", bus.rd_en, 1'b0);
        checkOutput("lat_e0_valid", bus.valid_out, 1'b0);
        tick();
        checkOutput("lat_e1_rd_en", bus.rd_en, 1'b1);
        checkOutput("lat_e1_rd_addr", bus.rd_addr, 0);
        checkOutput("lat_e1_valid", bus.valid_out, 1'b0);
        tick();
        checkOutput("lat_e2_valid", bus.valid_out, 1'b0);
        tick();
        checkOutput("lat_e3_valid", bus.valid_out, 1'b1);
        waitIdle("single", 60);
        checkOutput("single_run", lastRun, N);
        checkOutput("single_done_cnt", doneCount - doneBase, 1);
        checkOutput("single_busy", busy, 1'b0);

        // Backpressure: alternating ready with a longer stall early on.
        pushFrame();
        applyStimulus(1'b1, 1'b1);
        tick();
        enable = 1'b0;
        n = 0;
        while ((expQ.size() != 0 || busy) && n < 200) begin
            rdy = (n % 2 == 0) && !(n >= 4 && n < 10);
            applyStimulus(1'b0, rdy);
            tick();
            n++;
        end
        checkOutput("bp_timeout", n < 200, 1'b1);
        applyStimulus(1'b0, 1'b1);
        tick();
        tick();
        checkOutput("bp_queue_empty", expQ.size(), 0);

        // Back-to-back: enable sampled high on 20 edges covers three whole frames.
        pushFrame();
        pushFrame();
        pushFrame();
        doneBase = doneCount;
        applyStimulus(1'b1, 1'b1);
        repeat (20) tick();
        enable = 1'b0;
        waitIdle("b2b", 100);
        checkOutput("b2b_run", lastRun, 3 * N);
        checkOutput("b2b_done_cnt", doneCount - doneBase, 3);

        // Reset after three beats, then a clean restart at address 0.
        pushFrame();
        beatBase = beatCount;
        applyStimulus(1'b1, 1'b1);
        tick();
        enable = 1'b0;
        n = 0;
        while (beatCount < beatBase + 3 && n < 40) begin
            tick();
            n++;
        end
        checkOutput("mid_timeout", n < 40, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("mid_valid", bus.valid_out, 1'b0);
        checkOutput("mid_data", bus.data_out, 0);
        checkOutput("mid_sop", bus.sop_out, 1'b0);
        checkOutput("mid_rd_en", bus.rd_en, 1'b0);
        checkOutput("mid_busy", busy, 1'b0);
        expQ.delete();
        tick();
        @(negedge clk);
        reset = 1'b0;
        pushFrame();
        applyStimulus(1'b1, 1'b1);
        tick();
        enable = 1'b0;
        waitIdle("restart", 60);
        checkOutput("restart_run", lastRun, N);
        checkOutput("final_queue_empty", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
